la_upload_framer: RTL and testbench
===================================

Name: la_upload_framer

Overview:
Downstream stage of the logic-analyser capture path. Drains captured sample bytes from the capture FIFO, the same FIFO the analyser fills via dout/fifo_wen. Buffers up to PKT_LEN bytes, then frames them as an upload packet and hands the packet byte-by-byte to the UART transmitter using its tx_start/tx_data/tx_done handshake. Packet format: A5, 5A, SEQ, LEN, payload[LEN], CHK.

Parameters:
PKT_LEN, 64, payload bytes per full packet; legal range 1..255.
FLUSH_TIMEOUT, 50000, idle clk cycles with a partial buffer before forced close; must be >= 2.
HDR0, 8'hA5, first header byte.
HDR1, 8'h5A, second header byte.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  allows a new packet to start; does not abort a packet in progress
flush  in  1  single-cycle pulse; closes a partial packet immediately
fifo_empty  in  1  capture FIFO empty
fifo_ren  out  1  FIFO read strobe
fifo_rdata  in  8  FIFO read data, valid exactly 1 cycle after fifo_ren
tx_start  out  1  1-cycle pulse; starts one UART byte
tx_data  out  8  byte to transmit; held stable from tx_start until tx_done
tx_done  in  1  1-cycle pulse from UART when the byte is finished
busy  out  1  high in any state other than IDLE
pkt_cnt  out  16  packets fully sent since reset; wraps at 16'hFFFF

Behaviour:
- Reset values: fifo_ren=0, tx_start=0, tx_data=8'h00, busy=0, pkt_cnt=0. Internal SEQ=0, fill count=0, timeout counter=0, state IDLE. Reset mid-packet abandons the packet; no further tx_start until a new packet forms.
- States: IDLE, FILL, DRAIN, TX_H0, TX_H1, TX_SEQ, TX_LEN, TX_PL, TX_CHK.
- IDLE -> FILL when enable=1 and fifo_empty=0.
- FILL:
  - fifo_ren=1 in any cycle where fifo_empty=0 and reads issued < PKT_LEN. Back-to-back reads are allowed.
  - Each fifo_rdata is written to the internal buffer at index = bytes landed, 1 cycle after its ren.
  - The timeout counter clears on every ren and otherwise increments.
  - Close when any of: reads issued reaches PKT_LEN; flush=1 with >=1 read issued; timeout counter reaches FLUSH_TIMEOUT-1 with >=1 read issued.
  - flush with 0 reads issued is ignored. Reaching FILL implies a read is issued on its first cycle, so LEN is never 0.
- DRAIN: 1 cycle so the last in-flight read lands. LEN is latched as the landed count. Next state is TX_H0.
- Each TX_* state:
  - Issues exactly one tx_start pulse on its first cycle, with tx_data already set to the state's byte.
  - Waits for tx_done, then advances; the next tx_start comes the cycle after tx_done.
  - tx_done outside a TX wait is ignored.
  - Byte order: HDR0, HDR1, SEQ, LEN, buffer[0..LEN-1], CHK.
  - TX_PL repeats LEN times using an 8-bit payload index.
- CHK = (SEQ + LEN + sum of payload) mod 256; accumulated as bytes are sent.
- After tx_done of CHK: SEQ increments (8-bit wrap FF->00), pkt_cnt increments, state returns to IDLE. Back-to-back packets therefore always pass through IDLE for 1 cycle.
- enable dropping in any non-IDLE state has no effect on the current packet.
- No fifo_ren outside FILL; FIFO overflow upstream is not this block's concern.
- Internal buffer: PKT_LEN x 8 register or distributed RAM; write and read occur in disjoint phases.

Test Plan:
1. PKT_LEN=64, FIFO holds 0x00..0x3F -> bytes A5 5A 00 40 00..3F 20; pkt_cnt=1; busy low afterwards.
2. FLUSH_TIMEOUT=100, only 11 22 33 written, then FIFO empty -> about 100 cycles after last ren: A5 5A 00 03 11 22 33 69.
3. flush pulse in IDLE and with 0 bytes -> no tx_start. Then write FF and pulse flush -> A5 5A 00 01 FF 00.
4. 130 bytes 0x01 streamed, UART tx_done delay randomised 5..5000 cycles -> 3 packets: SEQ 00/01/02, LEN 40/40/02. tx_data stable during every byte; never two tx_start without an intervening tx_done; pkt_cnt=3.
5. enable=0 with data present -> stays IDLE with fifo_ren=0. Drop enable mid-payload -> packet completes normally.
6. Assert rst_n low during payload byte 10 -> all outputs reset immediately. Refill with 1 byte and flush -> new packet carries SEQ 00. Also drive 256 one-byte packets and confirm SEQ wraps FF->00.

Source files
------------

// File: rtl/la_upload_framer.sv
// Drains captured bytes from the capture FIFO into a packet buffer, then frames
// them as HDR0 HDR1 SEQ LEN payload CHK and feeds them one byte at a time to the UART.
module la_upload_framer #(
    parameter int unsigned PKT_LEN       = 64,
    parameter int unsigned FLUSH_TIMEOUT = 50000,
    parameter logic [7:0]  HDR0          = 8'hA5,
    parameter logic [7:0]  HDR1          = 8'h5A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        flush,
    input  logic        fifo_empty,
    output logic        fifo_ren,
    input  logic [7:0]  fifo_rdata,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        busy,
    output logic [15:0] pkt_cnt
);

    localparam int unsigned   AW       = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int unsigned   TW       = $clog2(FLUSH_TIMEOUT) + 1;
    localparam logic [7:0]    LEN_MAX  = 8'(PKT_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(FLUSH_TIMEOUT - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_FILL, ST_DRAIN, ST_TX_H0, ST_TX_H1,
        ST_TX_SEQ, ST_TX_LEN, ST_TX_PL, ST_TX_CHK
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      rd_cnt_q, rd_cnt_d;
    logic [7:0]      land_cnt_q, land_cnt_d;
    logic            ren_q;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      seq_q, seq_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      pl_idx_q, pl_idx_d;
    logic [7:0]      chk_q, chk_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [15:0]     pkt_cnt_q, pkt_cnt_d;
    logic            done_ok;
    logic [7:0]      buf_mem [PKT_LEN];

    assign fifo_ren = (state_q == ST_FILL) && !fifo_empty && (rd_cnt_q < LEN_MAX);
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = (state_q != ST_IDLE);
    assign pkt_cnt  = pkt_cnt_q;
    // A UART cannot finish a byte in the cycle it is started.
    assign done_ok  = tx_done && !tx_start_q;

    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        land_cnt_d = land_cnt_q;
        tmo_d      = tmo_q;
        seq_d      = seq_q;
        len_d      = len_q;
        pl_idx_d   = pl_idx_q;
        chk_d      = chk_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        pkt_cnt_d  = pkt_cnt_q;

        if (ren_q) land_cnt_d = land_cnt_q + 8'd1;

        case (state_q)
            ST_IDLE: begin
                rd_cnt_d   = '0;
                land_cnt_d = '0;
                tmo_d      = '0;
                if (enable && !fifo_empty) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (fifo_ren) begin
                    rd_cnt_d = rd_cnt_q + 8'd1;
                    tmo_d    = '0;
                end else if (tmo_q != TMO_LAST) begin
                    tmo_d = tmo_q + 1'b1;
                end
                if ((rd_cnt_d == LEN_MAX) ||
                    ((rd_cnt_d != 8'd0) && (flush || (tmo_q == TMO_LAST))))
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The last read lands this cycle, so the landed count is final here.
                len_d      = land_cnt_d;
                chk_d      = seq_q + land_cnt_d;
                pl_idx_d   = '0;
                state_d    = ST_TX_H0;
                tx_start_d = 1'b1;
                tx_data_d  = HDR0;
            end
            ST_TX_H0: if (done_ok) begin
                state_d    = ST_TX_H1;
                tx_start_d = 1'b1;
                tx_data_d  = HDR1;
            end
            ST_TX_H1: if (done_ok) begin
                state_d    = ST_TX_SEQ;
                tx_start_d = 1'b1;
                tx_data_d  = seq_q;
            end
            ST_TX_SEQ: if (done_ok) begin
                state_d    = ST_TX_LEN;
                tx_start_d = 1'b1;
                tx_data_d  = len_q;
            end
            ST_TX_LEN: if (done_ok) begin
                state_d    = ST_TX_PL;
                pl_idx_d   = '0;
                tx_start_d = 1'b1;
                tx_data_d  = buf_mem[pl_idx_d[AW-1:0]];
            end
            ST_TX_PL: if (done_ok) begin
                chk_d      = chk_q + tx_data_q;
                tx_start_d = 1'b1;
                if (pl_idx_q == len_q - 8'd1) begin
                    state_d   = ST_TX_CHK;
                    tx_data_d = chk_d;
                end else begin
                    pl_idx_d  = pl_idx_q + 8'd1;
                    tx_data_d = buf_mem[pl_idx_d[AW-1:0]];
                end
            end
            ST_TX_CHK: if (done_ok) begin
                seq_d     = seq_q + 8'd1;
                pkt_cnt_d = pkt_cnt_q + 16'd1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rd_cnt_q   <= '0;
            land_cnt_q <= '0;
            ren_q      <= 1'b0;
            tmo_q      <= '0;
            seq_q      <= '0;
            len_q      <= '0;
            pl_idx_q   <= '0;
            chk_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            land_cnt_q <= land_cnt_d;
            ren_q      <= fifo_ren;
            tmo_q      <= tmo_d;
            seq_q      <= seq_d;
            len_q      <= len_d;
            pl_idx_q   <= pl_idx_d;
            chk_q      <= chk_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    // Buffer is only written while filling and only read while transmitting.
    always_ff @(posedge clk) begin
        if (ren_q) buf_mem[land_cnt_q[AW-1:0]] <= fifo_rdata;
    end

endmodule

// File: tb/tb_la_upload_framer.sv
// Directed bench for la_upload_framer: FIFO and UART behavioural models plus
// one task per scenario, each comparing captured byte streams to hand-built packets.
module tb_la_upload_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic        fifo_empty;
    logic        fifo_ren;
    logic [7:0]  fifo_rdata = 8'h00;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic        busy;
    logic [15:0] pkt_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    la_upload_framer #(.PKT_LEN(64), .FLUSH_TIMEOUT(100)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .fifo_empty(fifo_empty), .fifo_ren(fifo_ren), .fifo_rdata(fifo_rdata),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .busy(busy), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // capture FIFO model: read data valid one cycle after ren
    logic [7:0] fmem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int last_ren_cyc = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_ren) begin
            fifo_rdata   <= fmem[rd_ptr[9:0]];
            rd_ptr       <= rd_ptr + 1;
            last_ren_cyc <= cyc;
        end
    end

    task automatic push(input logic [7:0] b);
        fmem[wr_ptr[9:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // UART model: logs each started byte, answers tx_done after a variable delay
    logic [7:0] txlog[$];
    logic       u_busy = 1'b0;
    logic [7:0] u_hold = 8'h00;
    int         u_cnt = 0;
    int         u_n = 0;
    int         proto_viol = 0;
    int         first_start_cyc = 0;
    int         dly_base = 5;
    int         dly_span = 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_busy  <= 1'b0;
            u_cnt   <= 0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (tx_start) begin
                if (u_busy) proto_viol <= proto_viol + 1;
                if (txlog.size() == 0) first_start_cyc <= cyc;
                txlog.push_back(tx_data);
                u_busy <= 1'b1;
                u_hold <= tx_data;
                u_cnt  <= dly_base + ((u_n * 37) % dly_span);
                u_n    <= u_n + 1;
            end else if (u_busy) begin
                if (tx_data !== u_hold) proto_viol <= proto_viol + 1;
                if (u_cnt == 0) begin
                    tx_done <= 1'b1;
                    u_busy  <= 1'b0;
                end else begin
                    u_cnt <= u_cnt - 1;
                end
            end
        end
    end

    // expected-stream model
    logic [7:0] exp_q[$];
    logic [7:0] pl[$];

    task automatic add_pkt(input logic [7:0] seq);
        logic [7:0] c;
        c = seq + 8'(pl.size());
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(seq);
        exp_q.push_back(8'(pl.size()));
        foreach (pl[i]) begin
            exp_q.push_back(pl[i]);
            c = c + pl[i];
        end
        exp_q.push_back(c);
        pl.delete();
    endtask

    function automatic int first_diff();
        int n;
        n = (txlog.size() < exp_q.size()) ? txlog.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (txlog[i] !== exp_q[i]) return i;
        if (txlog.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [7:0] log_at(input int i);
        return (i >= 0 && i < txlog.size()) ? txlog[i] : 8'hxx;
    endfunction

    function automatic logic [7:0] exp_at(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 8'hxx;
    endfunction

    task automatic wait_pkt(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pkt_cnt == 16'(target)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ren(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fifo_ren) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start got %b exp 0", tx_start); end
        checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL rst_fifo_ren got %b exp 0", fifo_ren); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h exp 00", tx_data); end
        checks++; if (pkt_cnt !== 16'h0) begin errors++; $display("FAIL rst_pkt_cnt got %h exp 0000", pkt_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_packet;
        bit ok;
        int d;
        txlog.delete(); exp_q.delete();
        for (int i = 0; i < 64; i++) begin push(8'(i)); pl.push_back(8'(i)); end
        add_pkt(8'h00);
        enable = 1'b1;
        wait_pkt(1, 20000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_timeout pkt_cnt got %0d exp 1", pkt_cnt); end
        d = first_diff();
        checks++; if (d != -1) begin errors++;
            $display("FAIL full_stream idx %0d got %h exp %h len %0d/%0d", d, log_at(d), exp_at(d), txlog.size(), exp_q.size()); end
        checks++; if (log_at(68) !== 8'h20) begin errors++; $display("FAIL full_chk got %h exp 20", log_at(68)); end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after got %b exp 0", busy); end
    endtask

    task automatic test_timeout;
        bit ok;
        int d;
        int lat;
        txlog.delete(); exp_q.delete();
        push(8'h11); push(8'h22); push(8'h33);
        pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
        add_pkt(8'h01);
        wait_pkt(2, 20000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_timeout pkt_cnt got %0d exp 2", pkt_cnt); end
        d = first_diff();
        checks++; if (d != -1) begin errors++;
            $display("FAIL tmo_stream idx %0d got %h exp %h len %0d/%0d", d, log_at(d), exp_at(d), txlog.size(), exp_q.size()); end
        checks++; if (log_at(7) !== 8'h6A) begin errors++; $display("FAIL tmo_chk got %h exp 6a", log_at(7)); end
        lat = first_start_cyc - last_ren_cyc;
        checks++; if (lat < 95 || lat > 110) begin errors++; $display("FAIL tmo_latency got %0d exp ~100", lat); end
    endtask

    task automatic test_flush;
        bit ok;
        int d;
        int fcyc;
        txlog.delete(); exp_q.delete();
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (txlog.size() != 0 || busy !== 1'b0) begin errors++;
            $display("FAIL flush_idle got %0d bytes busy %b exp 0 bytes busy 0", txlog.size(), busy); end
        push(8'hFF); pl.push_back(8'hFF); add_pkt(8'h02);
        wait_ren(20, ok);
        flush = 1'b1; fcyc = cyc; @(negedge clk); flush = 1'b0;
        wait_pkt(3, 5000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL flush_timeout pkt_cnt got %0d exp 3", pkt_cnt); end
        d = first_diff();
        checks++; if (d != -1) begin errors++;
            $display("FAIL flush_stream idx %0d got %h exp %h len %0d/%0d", d, log_at(d), exp_at(d), txlog.size(), exp_q.size()); end
        checks++; if (log_at(5) !== 8'h02) begin errors++; $display("FAIL flush_chk got %h exp 02", log_at(5)); end
        checks++; if (first_start_cyc - fcyc > 6) begin errors++;
            $display("FAIL flush_latency got %0d exp <=6", first_start_cyc - fcyc); end
    endtask

    task automatic test_stream;
        bit ok;
        int d;
        txlog.delete(); exp_q.delete();
        dly_base = 5; dly_span = 60;
        for (int i = 0; i < 130; i++) push(8'h01);
        for (int i = 0; i < 64; i++) pl.push_back(8'h01);
        add_pkt(8'h03);
        for (int i = 0; i < 64; i++) pl.push_back(8'h01);
        add_pkt(8'h04);
        pl.push_back(8'h01); pl.push_back(8'h01);
        add_pkt(8'h05);
        wait_pkt(6, 60000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stream_timeout pkt_cnt got %0d exp 6", pkt_cnt); end
        d = first_diff();
        checks++; if (d != -1) begin errors++;
            $display("FAIL stream_bytes idx %0d got %h exp %h len %0d/%0d", d, log_at(d), exp_at(d), txlog.size(), exp_q.size()); end
        checks++; if (proto_viol != 0) begin errors++; $display("FAIL stream_protocol got %0d exp 0", proto_viol); end
        dly_base = 5; dly_span = 1;
    endtask

    task automatic test_enable;
        bit ok;
        int d;
        int rp;
        txlog.delete(); exp_q.delete();
        enable = 1'b0;
        rp = rd_ptr;
        for (int i = 0; i < 64; i++) begin push(8'(i * 3)); pl.push_back(8'(i * 3)); end
        add_pkt(8'h06);
        repeat (30) @(negedge clk);
        checks++; if (rd_ptr != rp || busy !== 1'b0) begin errors++;
            $display("FAIL en_hold reads got %0d busy %b exp 0 busy 0", rd_ptr - rp, busy); end
        enable = 1'b1;
        for (int i = 0; i < 20000 && txlog.size() < 14; i++) @(negedge clk);
        enable = 1'b0;
        wait_pkt(7, 20000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL en_timeout pkt_cnt got %0d exp 7", pkt_cnt); end
        d = first_diff();
        checks++; if (d != -1) begin errors++;
            $display("FAIL en_stream idx %0d got %h exp %h len %0d/%0d", d, log_at(d), exp_at(d), txlog.size(), exp_q.size()); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_busy_after got %b exp 0", busy); end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid;
        bit ok;
        int d;
        int tmo;
        int bad_seq;
        logic [7:0] seqs [256];
        txlog.delete(); exp_q.delete();
        for (int i = 0; i < 64; i++) push(8'(8'h80 + i));
        for (int i = 0; i < 20000 && txlog.size() < 15; i++) @(negedge clk);
        checks++; if (log_at(14) !== 8'h8A) begin errors++; $display("FAIL rm_pl10 got %h exp 8a", log_at(14)); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || tx_start !== 1'b0 || fifo_ren !== 1'b0 || tx_data !== 8'h00 || pkt_cnt !== 16'h0) begin
            errors++;
            $display("FAIL rm_async busy %b start %b ren %b data %h cnt %h exp 0 0 0 00 0000",
                     busy, tx_start, fifo_ren, tx_data, pkt_cnt); end
        repeat (3) @(negedge clk);
        txlog.delete();
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (txlog.size() != 0) begin errors++; $display("FAIL rm_quiet got %0d bytes exp 0", txlog.size()); end
        push(8'h7E); pl.push_back(8'h7E); add_pkt(8'h00);
        wait_ren(20, ok);
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        wait_pkt(1, 5000, ok);
        d = first_diff();
        checks++; if (!ok || d != -1) begin errors++;
            $display("FAIL rm_new_pkt idx %0d got %h exp %h len %0d/%0d", d, log_at(d), exp_at(d), txlog.size(), exp_q.size()); end
        tmo = 0;
        for (int k = 0; k < 256; k++) begin
            txlog.delete();
            push(8'(k));
            wait_ren(20, ok);
            if (!ok) tmo++;
            flush = 1'b1; @(negedge clk); flush = 1'b0;
            wait_pkt(k + 2, 5000, ok);
            if (!ok) tmo++;
            seqs[k] = log_at(2);
        end
        checks++; if (tmo != 0) begin errors++; $display("FAIL wrap_timeouts got %0d exp 0", tmo); end
        checks++; if (seqs[254] !== 8'hFF || seqs[255] !== 8'h00) begin errors++;
            $display("FAIL wrap_seq got %h %h exp ff 00", seqs[254], seqs[255]); end
        bad_seq = 0;
        for (int k = 0; k < 256; k++) if (seqs[k] !== 8'(k + 1)) bad_seq++;
        checks++; if (bad_seq != 0) begin errors++; $display("FAIL wrap_seq_all got %0d bad exp 0", bad_seq); end
        checks++; if (pkt_cnt !== 16'd257) begin errors++; $display("FAIL wrap_pkt_cnt got %0d exp 257", pkt_cnt); end
        checks++; if (proto_viol != 0) begin errors++; $display("FAIL wrap_protocol got %0d exp 0", proto_viol); end
    endtask

    initial begin
        test_reset;
        test_full_packet;
        test_timeout;
        test_flush;
        test_stream;
        checks++; if (pkt_cnt !== 16'd6) begin errors++; $display("FAIL stream_pkt_cnt got %0d exp 6", pkt_cnt); end
        test_enable;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
